// File: rtl/fpu_pkg.sv
// Shared types and constants for the FP multiplier front end.
package fpu_pkg;

    typedef struct packed {
        logic        sign;
        logic [7:0]  exp;
        logic [22:0] frac;
    } fp32_t;

    typedef enum logic [2:0] {ZERO, NORMAL, DENORMAL, INF, NAN} fp_class_t;

    typedef enum logic [1:0] {ST_IDLE, ST_ISSUE, ST_WAIT, ST_RESP} disp_state_t;

    localparam logic [31:0] QUIET_NAN = 32'h7fffffff;
    localparam logic [7:0]  EXP_MAX   = 8'hff;
    localparam int unsigned MODE_W    = 7;

endpackage

// File: rtl/fp_classify.sv
// Combinational IEEE-754 single classifier; optionally flushes denormals to signed zero.
module fp_classify
    import fpu_pkg::*;
#(
    parameter bit FLUSH_DENORMALS = 1'b1
) (
    input  fp32_t     op_i,
    output fp_class_t cls_c_o,
    output fp32_t     op_c_o
);

    always_comb begin
        cls_c_o = NORMAL;
        op_c_o  = op_i;
        if (op_i.exp == EXP_MAX) begin
            cls_c_o = (op_i.frac == '0) ? INF : NAN;
        end else if (op_i.exp == '0) begin
            if (op_i.frac == '0) begin
                cls_c_o = ZERO;
            end else begin
                cls_c_o = DENORMAL;
                if (FLUSH_DENORMALS) op_c_o.frac = '0;
            end
        end
    end

endmodule

// File: rtl/fp_mul_dispatch.sv
// FP multiplier front end: captures an operand pair, issues it to the multiplier,
// waits for the result under a timeout and returns it on a valid/ready port.
module fp_mul_dispatch
    import fpu_pkg::*;
#(
    parameter bit          FLUSH_DENORMALS = 1'b1,
    parameter int unsigned TIMEOUT_CYCLES  = 16
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              req_valid_i,
    output logic              req_ready_o,
    input  logic [31:0]       x_i,
    input  logic [31:0]       y_i,
    input  logic [MODE_W-1:0] rounding_mode_i,
    output logic              mul_data_ready_o,
    output logic [MODE_W-1:0] mul_rounding_mode_o,
    output logic              x_sign_o,
    output logic              y_sign_o,
    output logic [7:0]        x_exp_o,
    output logic [7:0]        y_exp_o,
    output logic [22:0]       x_frac_o,
    output logic [22:0]       y_frac_o,
    output logic              x_infinity_o,
    output logic              y_infinity_o,
    output logic              x_nan_o,
    output logic              y_nan_o,
    input  logic              mul_data_valid_i,
    input  logic [31:0]       mul_z_i,
    input  logic              mul_invalid_i,
    input  logic              mul_overflow_i,
    output logic              resp_valid_o,
    input  logic              resp_ready_i,
    output logic [31:0]       z_o,
    output logic              except_invalid_operation_o,
    output logic              except_overflow_o,
    output logic              except_denormal_o,
    output logic              except_timeout_o
);

    localparam int unsigned      CNT_W    = $clog2(TIMEOUT_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    disp_state_t      state_q, state_d;
    logic [CNT_W-1:0] cnt_q;
    fp32_t            x_q, y_q;
    logic [MODE_W-1:0] mode_q;
    logic             x_inf_q, y_inf_q, x_nan_q, y_nan_q, den_q;
    logic [31:0]      z_q;
    logic             inv_q, ovf_q, tmo_q;
    logic             req_ready_q, req_ready_d;
    logic             strobe_q, strobe_d;
    logic             resp_valid_q, resp_valid_d;

    fp_class_t        x_cls_c, y_cls_c;
    fp32_t            x_flush_c, y_flush_c;
    logic             take_req_c, mul_done_c, timeout_c, resp_done_c;

    fp_classify #(.FLUSH_DENORMALS(FLUSH_DENORMALS)) u_cls_x (
        .op_i    (x_i),
        .cls_c_o (x_cls_c),
        .op_c_o  (x_flush_c)
    );

    fp_classify #(.FLUSH_DENORMALS(FLUSH_DENORMALS)) u_cls_y (
        .op_i    (y_i),
        .cls_c_o (y_cls_c),
        .op_c_o  (y_flush_c)
    );

    assign take_req_c  = (state_q == ST_IDLE) && req_valid_i;
    assign mul_done_c  = (state_q == ST_WAIT) && mul_data_valid_i;
    assign timeout_c   = (state_q == ST_WAIT) && !mul_data_valid_i && (cnt_q == CNT_LAST);
    assign resp_done_c = (state_q == ST_RESP) && resp_ready_i;

    always_ff @(posedge clk_i) begin
        if (rst_i) state_q <= ST_IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE:  if (take_req_c) state_d = ST_ISSUE;
            ST_ISSUE: state_d = ST_WAIT;
            ST_WAIT:  if (mul_done_c || timeout_c) state_d = ST_RESP;
            ST_RESP:  if (resp_done_c) state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // Handshake outputs are registered, so decode them from the next state.
    always_comb begin
        req_ready_d  = 1'b0;
        strobe_d     = 1'b0;
        resp_valid_d = 1'b0;
        unique case (state_d)
            ST_IDLE:  req_ready_d  = 1'b1;
            ST_ISSUE: strobe_d     = 1'b1;
            ST_RESP:  resp_valid_d = 1'b1;
            default:  ;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            req_ready_q  <= 1'b1;
            strobe_q     <= 1'b0;
            resp_valid_q <= 1'b0;
            cnt_q        <= '0;
            x_q          <= '0;
            y_q          <= '0;
            mode_q       <= '0;
            x_inf_q      <= 1'b0;
            y_inf_q      <= 1'b0;
            x_nan_q      <= 1'b0;
            y_nan_q      <= 1'b0;
            den_q        <= 1'b0;
            z_q          <= '0;
            inv_q        <= 1'b0;
            ovf_q        <= 1'b0;
            tmo_q        <= 1'b0;
        end else begin
            req_ready_q  <= req_ready_d;
            strobe_q     <= strobe_d;
            resp_valid_q <= resp_valid_d;
            if (take_req_c) begin
                x_q     <= x_flush_c;
                y_q     <= y_flush_c;
                mode_q  <= rounding_mode_i;
                x_inf_q <= (x_cls_c == INF);
                y_inf_q <= (y_cls_c == INF);
                x_nan_q <= (x_cls_c == NAN);
                y_nan_q <= (y_cls_c == NAN);
                den_q   <= (x_cls_c == DENORMAL) || (y_cls_c == DENORMAL);
            end
            if (state_q == ST_ISSUE)     cnt_q <= '0;
            else if (state_q == ST_WAIT) cnt_q <= cnt_q + CNT_W'(1);
            // Data arriving on the final count takes priority over the timeout.
            if (mul_done_c) begin
                z_q   <= mul_z_i;
                inv_q <= mul_invalid_i;
                ovf_q <= mul_overflow_i;
                tmo_q <= 1'b0;
            end else if (timeout_c) begin
                z_q   <= QUIET_NAN;
                inv_q <= 1'b1;
                ovf_q <= 1'b0;
                tmo_q <= 1'b1;
            end
        end
    end

    assign req_ready_o                = req_ready_q;
    assign mul_data_ready_o           = strobe_q;
    assign resp_valid_o               = resp_valid_q;
    assign mul_rounding_mode_o        = mode_q;
    assign x_sign_o                   = x_q.sign;
    assign y_sign_o                   = y_q.sign;
    assign x_exp_o                    = x_q.exp;
    assign y_exp_o                    = y_q.exp;
    assign x_frac_o                   = x_q.frac;
    assign y_frac_o                   = y_q.frac;
    assign x_infinity_o               = x_inf_q;
    assign y_infinity_o               = y_inf_q;
    assign x_nan_o                    = x_nan_q;
    assign y_nan_o                    = y_nan_q;
    assign z_o                        = z_q;
    assign except_invalid_operation_o = inv_q;
    assign except_overflow_o          = ovf_q;
    assign except_denormal_o          = den_q;
    assign except_timeout_o           = tmo_q;

endmodule
